// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 3-stage RISC-V core. Owns the program
// counter, addresses the synchronous-read instruction memory (one cycle of
// read latency) and hands decode an aligned instruction/PC pair. A one-entry
// skid register keeps the decode-side instruction steady while decode stalls,
// and an execute-stage redirect replaces the in-flight fetch with a single
// NOP bubble.
//
// Parameters
//   RESET_PC     first address fetched after reset
//   NOP          instruction shown to decode when nothing valid is available
//
// Ports
//   clk          core clock, all state changes on the rising edge
//   rst          synchronous, active-high reset
//   stall        decode cannot accept; decode-side outputs must hold
//   flush        redirect from execute; wins over stall
//   redirect_pc  redirect target (low two bits ignored)
//   imem_addr    byte address presented to IMEM/BIOS
//   imem_dout    memory data for the address presented on the previous cycle
//   inst         instruction to decode
//   inst_pc      PC of inst
//   inst_valid   1 when inst is a real instruction, 0 for a bubble
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  // Fetch address, and the address/validity of the word now in decode
  logic [31:0] r_pc;
  logic [31:0] r_dPc;
  logic        r_dValid;

  // Skid register: the memory keeps re-reading r_pc during a stall, so its
  // output no longer belongs to r_dPc; the decode word is parked here instead.
  logic        r_held;
  logic [31:0] r_holdInst;

  logic [31:0] w_inst;
  logic [31:0] w_redirectAligned;

  // Redirect targets are forced to word alignment; no misalignment trap here.
  assign w_redirectAligned = {redirect_pc[31:2], 2'b00};

  // Decode-side instruction: the parked word wins while a stall is in effect,
  // otherwise the memory output, otherwise a bubble.
  always_comb begin
    w_inst = NOP;
    if (r_held) begin
      w_inst = r_holdInst;
    end else if (r_dValid) begin
      w_inst = imem_dout;
    end
  end

  assign imem_addr  = r_pc;
  assign inst       = w_inst;
  assign inst_pc    = r_dPc;
  assign inst_valid = r_dValid;

  // Pipeline control, priority reset > flush > stall > advance. On a stall
  // the current decode word is captured once and then held for as long as the
  // stall lasts. On release the memory is already presenting inst(r_pc),
  // which becomes the new decode word, so nothing is skipped or repeated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_dPc      <= 32'h0;
      r_dValid   <= 1'b0;
      r_held     <= 1'b0;
      r_holdInst <= NOP;
    end else if (flush) begin
      r_pc     <= w_redirectAligned;
      r_dPc    <= 32'h0;
      r_dValid <= 1'b0;
      r_held   <= 1'b0;
    end else if (stall) begin
      if (!r_held) begin
        r_holdInst <= w_inst;
        r_held     <= 1'b1;
      end
    end else begin
      r_pc     <= r_pc + 32'd4;
      r_dPc    <= r_pc;
      r_dValid <= 1'b1;
      r_held   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A directed table walks through reset,
// streaming, stall, flush, flush+stall, reset during a stall and PC wrap, then
// a long randomized run is compared against a behavioural model that tracks
// only the architectural view: which address is being fetched and which PC
// decode holds, with the decode instruction always being the memory word at
// that PC (or NOP for a bubble).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int checks;
  int failures;

  // Model state: fetch address and the decode slot
  logic [31:0] mFetch;
  logic [31:0] mDecPc;
  logic        mDecValid;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] redirect;
    logic [31:0] expAddr;
    logic [31:0] expInst;
    logic [31:0] expPc;
    logic        expValid;
  } vec_t;

  vec_t vecQ[$];

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-derived memory contents (injective in the address)
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Synchronous-read instruction memory, one cycle of latency
  always @(posedge clk) begin
    imem_dout <= memWord(imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model with the
  // rules for that edge, and leave time just past the rising edge for checks.
  task automatic applyStimulus(input logic r, input logic f, input logic s,
                               input logic [31:0] rpc);
    @(negedge clk);
    rst         = r;
    flush       = f;
    stall       = s;
    redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      mFetch    = RESET_PC;
      mDecPc    = 32'h0;
      mDecValid = 1'b0;
    end else if (f) begin
      mFetch    = {rpc[31:2], 2'b00};
      mDecPc    = 32'h0;
      mDecValid = 1'b0;
    end else if (!s) begin
      mDecPc    = mFetch;
      mDecValid = 1'b1;
      mFetch    = mFetch + 32'd4;
    end
    #1;
  endtask

  task automatic addVec(input logic r, input logic f, input logic s,
                        input logic [31:0] rpc, input logic [31:0] addr,
                        input logic [31:0] pc, input logic v);
    vec_t t;
    t.rst      = r;
    t.flush    = f;
    t.stall    = s;
    t.redirect = rpc;
    t.expAddr  = addr;
    t.expPc    = pc;
    t.expValid = v;
    t.expInst  = v ? memWord(pc) : NOP;
    vecQ.push_back(t);
  endtask

  initial begin
    logic [31:0] expInst;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    stall       = 1'b0;
    redirect_pc = 32'h0;
    mFetch      = RESET_PC;
    mDecPc      = 32'h0;
    mDecValid   = 1'b0;

    // Directed sequence: inputs before the edge, outputs expected after it
    addVec(1, 0, 0, 32'h0,         32'h4000_0000, 32'h0,         0); // reset
    addVec(1, 0, 0, 32'h0,         32'h4000_0000, 32'h0,         0);
    addVec(0, 0, 0, 32'h0,         32'h4000_0004, 32'h4000_0000, 1); // first valid
    addVec(0, 0, 0, 32'h0,         32'h4000_0008, 32'h4000_0004, 1);
    addVec(0, 0, 0, 32'h0,         32'h4000_000C, 32'h4000_0008, 1);
    addVec(0, 0, 1, 32'h0,         32'h4000_000C, 32'h4000_0008, 1); // stall x3
    addVec(0, 0, 1, 32'h0,         32'h4000_000C, 32'h4000_0008, 1);
    addVec(0, 0, 1, 32'h0,         32'h4000_000C, 32'h4000_0008, 1);
    addVec(0, 0, 0, 32'h0,         32'h4000_0010, 32'h4000_000C, 1); // release
    addVec(0, 0, 0, 32'h0,         32'h4000_0014, 32'h4000_0010, 1);
    addVec(0, 1, 0, 32'h1000_0042, 32'h1000_0040, 32'h0,         0); // flush
    addVec(0, 0, 0, 32'h0,         32'h1000_0044, 32'h1000_0040, 1);
    addVec(0, 1, 1, 32'h1000_0100, 32'h1000_0100, 32'h0,         0); // flush+stall
    addVec(0, 0, 1, 32'h0,         32'h1000_0100, 32'h0,         0); // stall on bubble
    addVec(0, 0, 1, 32'h0,         32'h1000_0100, 32'h0,         0);
    addVec(0, 0, 0, 32'h0,         32'h1000_0104, 32'h1000_0100, 1);
    addVec(0, 0, 0, 32'h0,         32'h1000_0108, 32'h1000_0104, 1);
    addVec(0, 0, 1, 32'h0,         32'h1000_0108, 32'h1000_0104, 1); // stall
    addVec(1, 0, 1, 32'h0,         32'h4000_0000, 32'h0,         0); // reset mid-stall
    addVec(0, 0, 0, 32'h0,         32'h4000_0004, 32'h4000_0000, 1);
    addVec(0, 0, 0, 32'h0,         32'h4000_0008, 32'h4000_0004, 1);
    addVec(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         0); // wrap
    addVec(0, 0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1);
    addVec(0, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0000, 1);

    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i].rst, vecQ[i].flush, vecQ[i].stall, vecQ[i].redirect);
      checkOutput($sformatf("vec%0d imem_addr", i), imem_addr, vecQ[i].expAddr);
      checkOutput($sformatf("vec%0d inst", i), inst, vecQ[i].expInst);
      checkOutput($sformatf("vec%0d inst_pc", i), inst_pc, vecQ[i].expPc);
      checkOutput($sformatf("vec%0d inst_valid", i), {31'h0, inst_valid},
                  {31'h0, vecQ[i].expValid});
    end

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic f;
      logic s;
      r = ($urandom_range(99) < 2);
      f = ($urandom_range(99) < 10);
      s = ($urandom_range(99) < 35);
      applyStimulus(r, f, s, $urandom);
      expInst = mDecValid ? memWord(mDecPc) : NOP;
      checkOutput($sformatf("rnd%0d imem_addr", n), imem_addr, mFetch);
      checkOutput($sformatf("rnd%0d inst", n), inst, expInst);
      checkOutput($sformatf("rnd%0d inst_pc", n), inst_pc, mDecPc);
      checkOutput($sformatf("rnd%0d inst_valid", n), {31'h0, inst_valid},
                  {31'h0, mDecValid});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
